// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth/CSA multiply-accumulate unit.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL   = 2'b00,
        MUL_OP_MADD  = 2'b01,
        MUL_OP_MSUB  = 2'b10,
        MUL_OP_MTACC = 2'b11
    } mul_op_e;

    // Both depend on the instance WIDTH, so they are functions evaluated into localparams.
    function automatic int unsigned pp_count(input int unsigned width);
        return (width + 2) / 2;
    endfunction

    function automatic int unsigned tree_width(input int unsigned width);
        return 2 * width + 4;
    endfunction

endpackage

// File: rtl/booth_csa_tree.sv
// Radix-4 Booth partial products reduced to sum/carry vectors with 3:2 compressors.
module booth_csa_tree
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH+1:0]              xe,
    input  logic [WIDTH+1:0]              ye,
    output logic [tree_width(WIDTH)-1:0]  sum_o,
    output logic [tree_width(WIDTH)-1:0]  carry_o,
    output logic                          plus_one_o
);

    localparam int unsigned PP_N = pp_count(WIDTH);
    localparam int unsigned TW   = tree_width(WIDTH);

    logic [TW-1:0]    xs;
    logic [WIDTH+2:0] yx;

    assign xs = {{(TW-WIDTH-2){xe[WIDTH+1]}}, xe};
    assign yx = {ye, 1'b0};

    // The +1 of a negated row sits in the empty low bits of the next row;
    // only the last row's +1 has nowhere to go and is passed out.
    always_comb begin
        logic [WIDTH+2:0] ysh;
        logic [2:0]       grp;
        logic [TW-1:0]    mag;
        logic [TW-1:0]    row;
        logic [TW-1:0]    s;
        logic [TW-1:0]    c;
        logic [TW-1:0]    cy;
        logic             neg;
        logic             neg_prev;
        ysh      = '0;
        grp      = '0;
        mag      = '0;
        row      = '0;
        s        = '0;
        c        = '0;
        cy       = '0;
        neg      = 1'b0;
        neg_prev = 1'b0;
        for (int unsigned i = 0; i < PP_N; i++) begin
            ysh = yx >> (2 * i);
            grp = ysh[2:0];
            case (grp)
                3'b001, 3'b010, 3'b101, 3'b110: mag = xs;
                3'b011, 3'b100:                 mag = xs << 1;
                default:                        mag = '0;
            endcase
            neg = grp[2] & ~(grp[1] & grp[0]);
            row = (neg ? ~mag : mag) << (2 * i);
            if (i > 0) begin
                row = row | ({{(TW-1){1'b0}}, neg_prev} << (2 * i - 2));
            end
            if (i == 0) begin
                s = row;
            end else if (i == 1) begin
                c = row;
            end else begin
                cy = (s & c) | (s & row) | (c & row);
                s  = s ^ c ^ row;
                c  = cy << 1;
            end
            neg_prev = neg;
        end
        sum_o      = s;
        carry_o    = c;
        plus_one_o = neg_prev;
    end

endmodule

// File: rtl/mul_acc_pipe.sv
// Two-stage multiply-accumulate: Booth/CSA tree registered in stage 1, final add and
// accumulator update in stage 2, valid/ready on both sides with flush.
module mul_acc_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic                 mul_clk,
    input  logic                 mul_reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [2*WIDTH-1:0]   acc_q
);

    localparam int unsigned TW = tree_width(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    logic             adv;
    logic             accept;
    mul_op_e          op_in;
    logic [WIDTH+1:0] xe;
    logic [WIDTH+1:0] ye;
    logic [TW-1:0]    tree_sum;
    logic [TW-1:0]    tree_carry;
    logic             tree_one;

    logic             s1_valid_q, s1_valid_d;
    mul_op_e          s1_op_q,    s1_op_d;
    logic [TW-1:0]    s1_sum_q,   s1_sum_d;
    logic [TW-1:0]    s1_carry_q, s1_carry_d;
    logic             s1_one_q,   s1_one_d;
    logic [W2-1:0]    s1_xy_q,    s1_xy_d;
    logic             out_valid_q, out_valid_d;
    logic [W2-1:0]    result_q,   result_d;
    logic [W2-1:0]    acc_d;

    logic [TW-1:0]    one_vec;
    logic [TW-1:0]    full_sum;
    logic [W2-1:0]    prod;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !flush && !mul_reset;
    assign accept   = in_valid && in_ready;
    assign op_in    = ACC_EN ? mul_op_e'(in_op) : MUL_OP_MUL;
    assign xe       = in_signed ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign ye       = in_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    assign out_valid = out_valid_q;
    assign result    = result_q;

    booth_csa_tree #(.WIDTH(WIDTH)) u_tree (
        .xe         (xe),
        .ye         (ye),
        .sum_o      (tree_sum),
        .carry_o    (tree_carry),
        .plus_one_o (tree_one)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_sum_d    = s1_sum_q;
        s1_carry_d  = s1_carry_q;
        s1_one_d    = s1_one_q;
        s1_xy_d     = s1_xy_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        acc_d       = acc_q;

        one_vec         = '0;
        one_vec[WIDTH]  = s1_one_q;
        full_sum        = s1_sum_q + s1_carry_q + one_vec;
        prod            = full_sum[W2-1:0];

        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d    = op_in;
                s1_sum_d   = tree_sum;
                s1_carry_d = tree_carry;
                s1_one_d   = tree_one;
                s1_xy_d    = {x, y};
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                case (s1_op_q)
                    MUL_OP_MADD: begin
                        acc_d    = acc_q + prod;
                        result_d = acc_q + prod;
                    end
                    MUL_OP_MSUB: begin
                        acc_d    = acc_q - prod;
                        result_d = acc_q - prod;
                    end
                    MUL_OP_MTACC: begin
                        acc_d    = s1_xy_q;
                        result_d = s1_xy_q;
                    end
                    default: result_d = prod;
                endcase
            end
        end

        // A flush kills the stage-2 op before it can touch result or accumulator.
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            result_d    = result_q;
            acc_d       = acc_q;
        end

        if (!ACC_EN) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge mul_clk) begin
        if (mul_reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= MUL_OP_MUL;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_one_q    <= 1'b0;
            s1_xy_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            s1_one_q    <= s1_one_d;
            s1_xy_q     <= s1_xy_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
        end
    end

endmodule
